// File: rtl/program_loader_if.sv
// Stream and external-memory bundle between a word source, the loader
// and the cpu's instruction/data sram write ports.
interface program_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  addr_ext,
        input  wen_ext,
        input  ren_ext,
        input  wdata_ext,
        input  addr_ext_2,
        input  wen_ext_2,
        input  ren_ext_2,
        input  wdata_ext_2
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output addr_ext,
        output wen_ext,
        output ren_ext,
        output wdata_ext,
        output addr_ext_2,
        output wen_ext_2,
        output ren_ext_2,
        output wdata_ext_2
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: header + imem words + dmem words from a stream, then cpu enable.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum word.
module program_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int ADDR_STEP  = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_enable,
    output logic            busy,
    output logic            done,
    output logic            error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HEADER, LOAD_I, LOAD_D, CHECK, FINISH, RUN, ERR
    } state_e;
    localparam state_e TAIL = CHECK;
`else
    typedef enum logic [2:0] {
        IDLE, HEADER, LOAD_I, LOAD_D, FINISH, RUN, ERR
    } state_e;
    localparam state_e TAIL = FINISH;
`endif

    localparam logic [31:0] IMEM_LIM = 32'(IMEM_DEPTH);
    localparam logic [31:0] DMEM_LIM = 32'(DMEM_DEPTH);
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);

    state_e      state_q, state_d;
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [15:0] idx_q, idx_d;
    logic        iwen_q, iwen_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] idata_q, idata_d;
    logic        dwen_q, dwen_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] ddata_q, ddata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        s_ready;
    logic        beat;
    logic [15:0] hdr_i;
    logic [15:0] hdr_d;
    logic        hdr_bad;
    logic [31:0] word_addr;
    logic        last_i;
    logic        last_d;

    assign beat      = bus.s_valid && s_ready;
    assign hdr_i     = bus.s_data[31:16];
    assign hdr_d     = bus.s_data[15:0];
    assign hdr_bad   = ({16'd0, hdr_i} > IMEM_LIM) ||
                       ({16'd0, hdr_d} > DMEM_LIM);
    assign word_addr = 32'(idx_q) * STEP;
    assign last_i    = (idx_q == icnt_q - 16'd1);
    assign last_d    = (idx_q == dcnt_q - 16'd1);

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        iwen_d  = 1'b0;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        dwen_d  = 1'b0;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d = HEADER;
                    idx_d   = 16'd0;
                end
            end
            HEADER: begin
                if (beat) begin
                    icnt_d = hdr_i;
                    dcnt_d = hdr_d;
                    idx_d  = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = bus.s_data;
`endif
                    if (hdr_bad)
                        state_d = ERR;
                    else if (hdr_i != 16'd0)
                        state_d = LOAD_I;
                    else if (hdr_d != 16'd0)
                        state_d = LOAD_D;
                    else
                        state_d = TAIL;
                end
            end
            LOAD_I: begin
                if (beat) begin
                    iwen_d  = 1'b1;
                    iaddr_d = word_addr;
                    idata_d = bus.s_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.s_data;
`endif
                    if (last_i) begin
                        idx_d   = 16'd0;
                        state_d = (dcnt_q != 16'd0) ? LOAD_D : TAIL;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            LOAD_D: begin
                if (beat) begin
                    dwen_d  = 1'b1;
                    daddr_d = word_addr;
                    ddata_d = bus.s_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.s_data;
`endif
                    if (last_d) begin
                        idx_d   = 16'd0;
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                // trailer is compared only; neither memory sees it
                if (beat)
                    state_d = (bus.s_data == sum_q) ? FINISH : ERR;
            end
`endif
            // last strobe is on the bus during this cycle
            FINISH: state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            icnt_q  <= '0;
            dcnt_q  <= '0;
            idx_q   <= '0;
            iwen_q  <= 1'b0;
            iaddr_q <= '0;
            idata_q <= '0;
            dwen_q  <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            iwen_q  <= iwen_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
            dwen_q  <= dwen_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end
`endif

    always_comb begin
        s_ready    = 1'b0;
        busy       = 1'b0;
        cpu_enable = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            HEADER, LOAD_I, LOAD_D: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
`endif
            FINISH: busy = 1'b1;
            RUN: begin
                cpu_enable = 1'b1;
                done       = 1'b1;
            end
            ERR: error = 1'b1;
            default: ;
        endcase
    end

    assign bus.s_ready     = s_ready;
    assign bus.addr_ext    = iaddr_q;
    assign bus.wen_ext     = iwen_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.wdata_ext   = idata_q;
    assign bus.addr_ext_2  = daddr_q;
    assign bus.wen_ext_2   = dwen_q;
    assign bus.ren_ext_2   = 1'b0;
    assign bus.wdata_ext_2 = ddata_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a queue-based model of the
// expected memory writes and session outcome.
module tb_program_loader;
    localparam int IMEM_DEPTH = 512;
    localparam int DMEM_DEPTH = 1024;
    localparam int ADDR_STEP  = 4;
    localparam int CYC_LIMIT  = 20000;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    logic start  = 1'b0;
    logic cpu_enable;
    logic busy;
    logic done;
    logic error;

    program_loader_if bus();

    program_loader dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .bus       (bus),
        .cpu_enable(cpu_enable),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_i[$];
    logic [63:0] exp_d[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every strobe must match the next write the model predicts
    always @(negedge clk) begin
        if (arst_n && (bus.wen_ext || bus.wen_ext_2)) begin
            chk("wen_excl", 64'(bus.wen_ext && bus.wen_ext_2), 64'd0);
            chk("ren_zero", 64'({bus.ren_ext, bus.ren_ext_2}), 64'd0);
            if (bus.wen_ext) begin
                chk("imem_expected", 64'(exp_i.size() != 0), 64'd1);
                if (exp_i.size() != 0)
                    chk("imem_write", {bus.addr_ext, bus.wdata_ext},
                        exp_i.pop_front());
            end
            if (bus.wen_ext_2) begin
                chk("dmem_expected", 64'(exp_d.size() != 0), 64'd1);
                if (exp_d.size() != 0)
                    chk("dmem_write", {bus.addr_ext_2, bus.wdata_ext_2},
                        exp_d.pop_front());
            end
        end
    end

    function automatic logic [63:0] ctl();
        return 64'({bus.s_ready, cpu_enable, done, error, busy});
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // offers words at negedges; returns at the negedge after the last beat
    task automatic drive(input logic [31:0] w[$], input int mode,
                         input int limit);
        int  i   = 0;
        int  cyc = 0;
        bit  acc;
        while (i < limit && cyc < CYC_LIMIT) begin
            case (mode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (cyc % 2 == 0);
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = bus.s_valid ? w[i] : $urandom;
            if (mode == 2)
                start = ($urandom_range(0, 7) == 0);
            acc = bus.s_valid && bus.s_ready;
            @(negedge clk);
            cyc++;
            if (acc)
                i++;
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        chk("drive_in_time", 64'(cyc < CYC_LIMIT), 64'd1);
    endtask

    task automatic run_session(input int ic, input int dc, input int mode,
                               input bit bad_sum);
        logic [31:0] w[$];
        logic [31:0] v;
        logic [31:0] sum;
        bit          legal;
        bit          good;
        w.push_back({ic[15:0], dc[15:0]});
        sum   = w[0];
        legal = (ic <= IMEM_DEPTH) && (dc <= DMEM_DEPTH);
        good  = legal;
        if (legal) begin
            for (int i = 0; i < ic; i++) begin
                v = $urandom;
                w.push_back(v);
                exp_i.push_back({32'(i * ADDR_STEP), v});
                sum += v;
            end
            for (int j = 0; j < dc; j++) begin
                v = $urandom;
                w.push_back(v);
                exp_d.push_back({32'(j * ADDR_STEP), v});
                sum += v;
            end
`ifdef LOADER_CHECKSUM_EN
            w.push_back(bad_sum ? sum + 32'd1 : sum);
            good = !bad_sum;
`endif
        end
        pulse_start();
        drive(w, mode, w.size());
        if (good) begin
            chk("finish_ctl", ctl(), 64'b00001);
            @(negedge clk);
            chk("run_ctl", ctl(), 64'b01100);
        end else begin
            chk("err_ctl", ctl(), 64'b00010);
            @(negedge clk);
        end
        chk("imem_left", 64'(exp_i.size()), 64'd0);
        chk("dmem_left", 64'(exp_d.size()), 64'd0);
        exp_i.delete();
        exp_d.delete();
    endtask

    task automatic reset_mid_load();
        logic [31:0] w[$];
        logic [31:0] v;
        w.push_back(32'h0003_0002);
        for (int i = 0; i < 2; i++) begin
            v = $urandom;
            w.push_back(v);
            exp_i.push_back({32'(i * ADDR_STEP), v});
        end
        pulse_start();
        drive(w, 0, 3);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({bus.s_ready, bus.wen_ext, bus.wen_ext_2,
            bus.ren_ext, bus.ren_ext_2, cpu_enable, busy, done, error}),
            64'd0);
        chk("mid_rst_imem", {bus.addr_ext, bus.wdata_ext}, 64'd0);
        chk("mid_rst_dmem", {bus.addr_ext_2, bus.wdata_ext_2}, 64'd0);
        #1 arst_n = 1'b1;
        chk("mid_imem_left", 64'(exp_i.size()), 64'd0);
        exp_i.delete();
        exp_d.delete();
    endtask

    initial begin
        int ic;
        int dc;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #3;
        chk("rst_ctl", 64'({bus.s_ready, bus.wen_ext, bus.wen_ext_2,
            bus.ren_ext, bus.ren_ext_2, cpu_enable, busy, done, error}),
            64'd0);
        chk("rst_imem", {bus.addr_ext, bus.wdata_ext}, 64'd0);
        chk("rst_dmem", {bus.addr_ext_2, bus.wdata_ext_2}, 64'd0);
        #9 arst_n = 1'b1;

        run_session(3, 2, 0, 1'b0);
        run_session(3, 2, 1, 1'b0);
        run_session(513, 0, 0, 1'b0);
        run_session(3, 2, 0, 1'b0);
        run_session(0, 0, 0, 1'b0);
        reset_mid_load();
        run_session(3, 2, 0, 1'b0);
        run_session(0, 1025, 0, 1'b0);
        run_session(IMEM_DEPTH, 0, 0, 1'b0);
        run_session(0, DMEM_DEPTH, 2, 1'b0);
        run_session(1, 0, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        run_session(1, 0, 0, 1'b1);
        run_session(2, 3, 2, 1'b1);
`endif
        for (int k = 0; k < 16; k++) begin
            ic = $urandom_range(0, 6);
            dc = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0)
                ic = $urandom_range(IMEM_DEPTH + 1, 700);
            else if ($urandom_range(0, 5) == 0)
                dc = $urandom_range(DMEM_DEPTH + 1, 1200);
            run_session(ic, dc, $urandom_range(0, 2),
                        1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
